change_dispenser: RTL and testbench
===================================

# change_dispenser

Downstream stage of the vending machine controller. It accepts a change amount in nickels, then pays it out one coin at a time through three coin ejectors (quarter, dime, nickel). Each ejection is confirmed by the shared exit-chute coin sensor. The block tracks per-coin inventory and reports completion or a fault (out of coins, or a jam) together with the amount still owed.

## Interface
Parameters:
- AMT_W, 6: width of amounts, in nickels.
- INV_W, 8: width of each coin inventory counter.
- PULSE_CYCLES, 4: width of an ejector pulse in cycles (≥1).
- ACK_TIMEOUT, 16: cycles to wait for the coin sensor after a pulse ends (≥1).

Ports:
- clk, in, 1: single clock. Everything is on the rising edge.
- rst, in, 1: reset, synchronous, active-high.
- req_valid, in, 1: a change request is presented.
- req_amount, in, AMT_W: the amount owed, in nickels.
- req_ready, out, 1: the block can accept a request.
- inv_load, in, 1: load the three inventory counters.
- inv_q_in / inv_d_in / inv_n_in, in, INV_W: inventory load values.
- eject_q / eject_d / eject_n, out, 1: ejector drive pulses.
- coin_sensed, in, 1: single-cycle pulse from the exit sensor.
- inv_q / inv_d / inv_n, out, INV_W: current inventory.
- busy, out, 1: the block is not in IDLE.
- done, out, 1: one-cycle pulse that ends a request.
- fault, out, 1: qualifies `done`. 0 = paid in full, 1 = failed.
- fault_code, out, 2: valid while `fault` is 1. 01 = no payable coin, 10 = sensor timeout.
- remaining, out, AMT_W: amount still owed, in nickels. Holds its value after `done`.

## Operation
States: IDLE, SELECT, EJECT, WAIT, DONE.

- **IDLE**
  - req_ready=1.
  - A handshake (req_valid & req_ready) latches req_amount into `remaining`, then goes to SELECT.
  - inv_load is honoured only in IDLE and is ignored in every other state.
  - If inv_load and a handshake occur in the same cycle, both take effect. SELECT then uses the newly loaded values.
- **SELECT**
  - remaining==0: go to DONE with fault=0.
  - Otherwise choose a coin greedily, in this order:
    - quarter (5), if remaining≥5 and inv_q>0;
    - else dime (2), if remaining≥2 and inv_d>0;
    - else nickel (1), if inv_n>0.
  - If no coin qualifies: go to DONE with fault=1, fault_code=01.
  - Greedy selection is a decided design choice. It may fault where a different coin mix would succeed, e.g. remaining=6, inv_n=0: one quarter is paid, then remaining=1 faults.
- **EJECT**
  - The selected ejector is held high for exactly PULSE_CYCLES cycles. The other two stay low. Then go to WAIT.
- **WAIT**
  - coin_sensed=1: subtract the coin value from `remaining`, decrement that coin's inventory by 1, then go to SELECT.
  - A timeout occurs after ACK_TIMEOUT cycles with no sense. Then go to DONE with fault=1, fault_code=10. Neither `remaining` nor inventory changes.
  - If coin_sensed arrives in the last timeout cycle, the sense wins.
- **DONE**
  - done=1 for one cycle, with fault and fault_code driven. Then go to IDLE.
- **Sensor rule:** coin_sensed is ignored outside WAIT, including during EJECT.
- **Arithmetic:** subtraction cannot underflow, because a coin is chosen only if its value ≤ remaining. Inventory cannot underflow, because a coin is chosen only if its count > 0.
- **Unchanged values:** req_amount=0 completes with fault=0 and ejects no coin. A new request after a fault reloads `remaining`. Inventory is never changed except by inv_load or a sensed coin.

## Timing
- **Reset:**
  - state=IDLE.
  - Zero: remaining, all inventory counters, eject_*, done, fault, fault_code, busy.
  - req_ready=0 during the reset cycle, 1 in the first cycle after it.
- **Reset mid-operation:** the next cycle is IDLE with all of the above values. Any ejector pulse stops immediately.
- **Latency:** for a handshake in cycle T:
  - SELECT in T+1;
  - eject high in T+2 … T+1+PULSE_CYCLES;
  - WAIT from T+2+PULSE_CYCLES.
- **After a sense** in cycle W: SELECT in W+1; the next eject or DONE follows in W+2.
- **Zero amount:** done in T+2.
- **Timeout:** with no sense, DONE falls exactly ACK_TIMEOUT cycles after WAIT is entered.
- **Output qualification:**
  - busy is 0 only in IDLE.
  - req_ready equals NOT busy, except during reset.
  - done, fault and fault_code are 0 outside the DONE cycle.
  - All outputs are registered or decoded from the state register only.

## Test plan
- **Amount 7, full inventory (10/10/10), sensor replies 2 cycles into each WAIT (defaults):** eject_q pulse of 4 cycles, then eject_d pulse of 4 cycles. Then done=1, fault=0, remaining=0; inventory ends 9/9/10.
- **Amount 0 accepted at T:** done=1 with fault=0 at T+2. No eject pulses; busy is high in T+1..T+2.
- **Amount 6, inventory 5/0/0:** one quarter is paid, then done with fault=1, fault_code=01, remaining=1; inv_q=4.
- **Amount 2, dime ejected, no sense:** DONE comes 16 cycles after WAIT entry with fault_code=10, remaining=2; inv_d is unchanged.
- **coin_sensed during EJECT, then in the last timeout cycle:** the first sense is ignored, the second is accepted, and the payout completes.
- **Reset asserted during eject_n:** eject_n=0 and state is IDLE next cycle, with inventory and remaining cleared. inv_load asserted while busy is ignored.

Source files
------------

// File: rtl/change_dispenser_if.sv
// Request/result handshake between the vending controller and the change dispenser.
interface change_dispenser_if #(
    parameter int AMT_W = 6
);
    logic             req_valid;
    logic [AMT_W-1:0] req_amount;
    logic             req_ready;
    logic             done;
    logic             fault;
    logic [1:0]       fault_code;
    logic [AMT_W-1:0] remaining;

    modport master (
        output req_valid, req_amount,
        input  req_ready, done, fault, fault_code, remaining
    );

    modport slave (
        input  req_valid, req_amount,
        output req_ready, done, fault, fault_code, remaining
    );
endinterface

// File: rtl/change_dispenser.sv
// Pays out a change amount coin by coin (greedy quarter/dime/nickel), confirming each
// coin with the exit-chute sensor and tracking per-coin inventory.
//
// state    | meaning
// S_IDLE   | ready for a request; inventory may be loaded
// S_SELECT | pick the next coin, or finish when nothing is owed / no coin fits
// S_EJECT  | drive the chosen ejector for PULSE_CYCLES cycles
// S_WAIT   | wait up to ACK_TIMEOUT cycles for the sensor to confirm the coin
// S_DONE   | one-cycle completion pulse with fault status
module change_dispenser #(
    parameter int AMT_W        = 6,
    parameter int INV_W        = 8,
    parameter int PULSE_CYCLES = 4,
    parameter int ACK_TIMEOUT  = 16
) (
    input  logic               clk,
    input  logic               rst,
    change_dispenser_if.slave  req_if,
    input  logic               inv_load,
    input  logic [INV_W-1:0]   inv_q_in,
    input  logic [INV_W-1:0]   inv_d_in,
    input  logic [INV_W-1:0]   inv_n_in,
    output logic               eject_q,
    output logic               eject_d,
    output logic               eject_n,
    input  logic               coin_sensed,
    output logic [INV_W-1:0]   inv_q,
    output logic [INV_W-1:0]   inv_d,
    output logic [INV_W-1:0]   inv_n,
    output logic               busy
);
    localparam int CNT_MAX = (PULSE_CYCLES > ACK_TIMEOUT) ? PULSE_CYCLES : ACK_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ACK_LOAD   = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [AMT_W-1:0] VAL_Q = AMT_W'(5);
    localparam logic [AMT_W-1:0] VAL_D = AMT_W'(2);
    localparam logic [AMT_W-1:0] VAL_N = AMT_W'(1);

    typedef enum logic [2:0] {S_IDLE, S_SELECT, S_EJECT, S_WAIT, S_DONE} state_t;
    typedef enum logic [1:0] {COIN_NONE, COIN_Q, COIN_D, COIN_N} coin_t;

    state_t           state_q, state_d;
    coin_t            coin_q, coin_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AMT_W-1:0] rem_q, rem_d;
    logic [INV_W-1:0] inv_qtr_q, inv_qtr_d;
    logic [INV_W-1:0] inv_dim_q, inv_dim_d;
    logic [INV_W-1:0] inv_nck_q, inv_nck_d;
    logic             ej_qtr_q, ej_qtr_d;
    logic             ej_dim_q, ej_dim_d;
    logic             ej_nck_q, ej_nck_d;
    logic             done_q, done_d;
    logic             fault_q, fault_d;
    logic [1:0]       fault_code_q, fault_code_d;
    logic [AMT_W-1:0] coin_val;

    always_comb begin
        coin_val = '0;
        case (coin_q)
            COIN_Q:  coin_val = VAL_Q;
            COIN_D:  coin_val = VAL_D;
            COIN_N:  coin_val = VAL_N;
            default: coin_val = '0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        coin_d       = coin_q;
        cnt_d        = cnt_q;
        rem_d        = rem_q;
        inv_qtr_d    = inv_qtr_q;
        inv_dim_d    = inv_dim_q;
        inv_nck_d    = inv_nck_q;
        ej_qtr_d     = ej_qtr_q;
        ej_dim_d     = ej_dim_q;
        ej_nck_d     = ej_nck_q;
        done_d       = 1'b0;
        fault_d      = 1'b0;
        fault_code_d = 2'b00;

        case (state_q)
            S_IDLE: begin
                if (inv_load) begin
                    inv_qtr_d = inv_q_in;
                    inv_dim_d = inv_d_in;
                    inv_nck_d = inv_n_in;
                end
                if (req_if.req_valid) begin
                    rem_d   = req_if.req_amount;
                    state_d = S_SELECT;
                end
            end
            S_SELECT: begin
                if (rem_q == '0) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else if (rem_q >= VAL_Q && inv_qtr_q != '0) begin
                    coin_d   = COIN_Q;
                    ej_qtr_d = 1'b1;
                    cnt_d    = PULSE_LOAD;
                    state_d  = S_EJECT;
                end else if (rem_q >= VAL_D && inv_dim_q != '0) begin
                    coin_d   = COIN_D;
                    ej_dim_d = 1'b1;
                    cnt_d    = PULSE_LOAD;
                    state_d  = S_EJECT;
                end else if (inv_nck_q != '0) begin
                    coin_d   = COIN_N;
                    ej_nck_d = 1'b1;
                    cnt_d    = PULSE_LOAD;
                    state_d  = S_EJECT;
                end else begin
                    state_d      = S_DONE;
                    done_d       = 1'b1;
                    fault_d      = 1'b1;
                    fault_code_d = 2'b01;
                end
            end
            S_EJECT: begin
                if (cnt_q == '0) begin
                    ej_qtr_d = 1'b0;
                    ej_dim_d = 1'b0;
                    ej_nck_d = 1'b0;
                    cnt_d    = ACK_LOAD;
                    state_d  = S_WAIT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_WAIT: begin
                // A sense in the final timeout cycle still counts as a paid coin.
                if (coin_sensed) begin
                    rem_d = rem_q - coin_val;
                    case (coin_q)
                        COIN_Q:  inv_qtr_d = inv_qtr_q - INV_W'(1);
                        COIN_D:  inv_dim_d = inv_dim_q - INV_W'(1);
                        COIN_N:  inv_nck_d = inv_nck_q - INV_W'(1);
                        default: ;
                    endcase
                    state_d = S_SELECT;
                end else if (cnt_q == '0) begin
                    state_d      = S_DONE;
                    done_d       = 1'b1;
                    fault_d      = 1'b1;
                    fault_code_d = 2'b10;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            coin_q       <= COIN_NONE;
            cnt_q        <= '0;
            rem_q        <= '0;
            inv_qtr_q    <= '0;
            inv_dim_q    <= '0;
            inv_nck_q    <= '0;
            ej_qtr_q     <= 1'b0;
            ej_dim_q     <= 1'b0;
            ej_nck_q     <= 1'b0;
            done_q       <= 1'b0;
            fault_q      <= 1'b0;
            fault_code_q <= 2'b00;
        end else begin
            state_q      <= state_d;
            coin_q       <= coin_d;
            cnt_q        <= cnt_d;
            rem_q        <= rem_d;
            inv_qtr_q    <= inv_qtr_d;
            inv_dim_q    <= inv_dim_d;
            inv_nck_q    <= inv_nck_d;
            ej_qtr_q     <= ej_qtr_d;
            ej_dim_q     <= ej_dim_d;
            ej_nck_q     <= ej_nck_d;
            done_q       <= done_d;
            fault_q      <= fault_d;
            fault_code_q <= fault_code_d;
        end
    end

    // Ready is held off while reset is asserted even though the state is already IDLE.
    assign busy              = (state_q != S_IDLE);
    assign req_if.req_ready  = (state_q == S_IDLE) && !rst;
    assign req_if.done       = done_q;
    assign req_if.fault      = fault_q;
    assign req_if.fault_code = fault_code_q;
    assign req_if.remaining  = rem_q;
    assign eject_q           = ej_qtr_q;
    assign eject_d           = ej_dim_q;
    assign eject_n           = ej_nck_q;
    assign inv_q             = inv_qtr_q;
    assign inv_d             = inv_dim_q;
    assign inv_n             = inv_nck_q;
endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: table of payout requests with a result scoreboard,
// plus hand-written sequences for reset, latency and reset-during-eject.
module tb_change_dispenser;
    localparam int AMT_W = 6;
    localparam int INV_W = 8;
    localparam int PULSE = 4;
    localparam int ACK   = 16;

    typedef struct {
        int fault;
        int code;
        int rem;
        int iq;
        int id;
        int inn;
    } exp_t;

    typedef struct {
        int   amount;
        int   iq;
        int   id;
        int   inn;
        int   delay;
        bit   eject_sense;
        exp_t e;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             inv_load = 1'b0;
    logic [INV_W-1:0] inv_q_in = '0;
    logic [INV_W-1:0] inv_d_in = '0;
    logic [INV_W-1:0] inv_n_in = '0;
    logic             eject_q, eject_d, eject_n;
    logic             coin_sensed = 1'b0;
    logic [INV_W-1:0] inv_q, inv_d, inv_n;
    logic             busy;

    change_dispenser_if #(.AMT_W(AMT_W)) dif ();

    change_dispenser #(
        .AMT_W(AMT_W), .INV_W(INV_W), .PULSE_CYCLES(PULSE), .ACK_TIMEOUT(ACK)
    ) dut (
        .clk(clk), .rst(rst), .req_if(dif),
        .inv_load(inv_load), .inv_q_in(inv_q_in), .inv_d_in(inv_d_in), .inv_n_in(inv_n_in),
        .eject_q(eject_q), .eject_d(eject_d), .eject_n(eject_n),
        .coin_sensed(coin_sensed),
        .inv_q(inv_q), .inv_d(inv_d), .inv_n(inv_n),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];
    vec_t vecs[8];

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual %0d, required %0d", name, act, req);
        end
    endtask

    function automatic exp_t mk_exp(int f, int cd, int rm, int eq, int ed, int en);
        exp_t e;
        e.fault = f; e.code = cd; e.rem = rm; e.iq = eq; e.id = ed; e.inn = en;
        return e;
    endfunction

    function automatic vec_t mk_vec(int amt, int iq, int id, int inn, int dly, bit es,
                                    int f, int cd, int rm, int eq, int ed, int en);
        vec_t v;
        v.amount = amt; v.iq = iq; v.id = id; v.inn = inn;
        v.delay = dly; v.eject_sense = es;
        v.e = mk_exp(f, cd, rm, eq, ed, en);
        return v;
    endfunction

    // Scoreboard: every done pulse retires the oldest expected result.
    always @(negedge clk) begin
        exp_t e;
        if (dif.done === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check("fault", int'(dif.fault), e.fault);
                check("fault_code", int'(dif.fault_code), e.code);
                check("remaining", int'(dif.remaining), e.rem);
                check("inv_q", int'(inv_q), e.iq);
                check("inv_d", int'(inv_d), e.id);
                check("inv_n", int'(inv_n), e.inn);
            end
        end else if (!rst) begin
            check("fault_outside_done", int'({dif.fault, dif.fault_code}), 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual no finish, required finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic run_vec(input vec_t v);
        int pulse_len   = 0;
        int wait_cnt    = 0;
        int since       = 0;
        bit in_wait     = 0;
        bit sensed_last = 0;
        bit finished    = 0;
        @(negedge clk);
        check("vec_ready", int'(dif.req_ready), 1);
        inv_load       = 1'b1;
        inv_q_in       = INV_W'(v.iq);
        inv_d_in       = INV_W'(v.id);
        inv_n_in       = INV_W'(v.inn);
        dif.req_valid  = 1'b1;
        dif.req_amount = AMT_W'(v.amount);
        sb_q.push_back(v.e);
        @(negedge clk);
        dif.req_valid = 1'b0;
        for (int c = 0; c < 800 && !finished; c++) begin
            if (c > 0) @(negedge clk);
            if (in_wait) wait_cnt++;
            since++;
            coin_sensed = 1'b0;
            inv_load    = 1'b0;
            if (dif.done === 1'b1) begin
                if (sensed_last) check("sense_to_done", since, 2);
                else if (in_wait) check("timeout_len", wait_cnt, ACK);
                check("busy_in_done", int'(busy), 1);
                finished = 1;
            end else if ({eject_q, eject_d, eject_n} != 3'b000) begin
                check("one_ejector", $countones({eject_q, eject_d, eject_n}), 1);
                pulse_len++;
                inv_load    = 1'b1;
                inv_q_in    = 8'hAA;
                inv_d_in    = 8'h55;
                inv_n_in    = 8'h0F;
                coin_sensed = v.eject_sense;
            end else begin
                if (pulse_len > 0) begin
                    check("pulse_len", pulse_len, PULSE);
                    pulse_len   = 0;
                    in_wait     = 1;
                    wait_cnt    = 0;
                    sensed_last = 0;
                end
                if (in_wait && v.delay >= 0 && wait_cnt == v.delay) begin
                    coin_sensed = 1'b1;
                    in_wait     = 0;
                    sensed_last = 1;
                    since       = 0;
                end
            end
        end
        coin_sensed = 1'b0;
        inv_load    = 1'b0;
        if (!finished) check("done_reached", 0, 1);
        @(negedge clk);
        check("idle_after_done", int'(busy), 0);
        check("done_one_cycle", int'(dif.done), 0);
        check("remaining_hold", int'(dif.remaining), v.e.rem);
    endtask

    initial begin
        dif.req_valid  = 1'b0;
        dif.req_amount = '0;

        vecs[0] = mk_vec(7, 10, 10, 10, 2, 0,     0, 0, 0, 9, 9, 10);
        vecs[1] = mk_vec(0, 10, 10, 10, 2, 0,     0, 0, 0, 10, 10, 10);
        vecs[2] = mk_vec(6, 5, 0, 0, 2, 0,        1, 1, 1, 4, 0, 0);
        vecs[3] = mk_vec(2, 3, 3, 3, -1, 0,       1, 2, 2, 3, 3, 3);
        vecs[4] = mk_vec(13, 10, 10, 10, 0, 0,    0, 0, 0, 8, 9, 9);
        vecs[5] = mk_vec(4, 0, 1, 5, 15, 1,       0, 0, 0, 0, 0, 3);
        vecs[6] = mk_vec(3, 0, 0, 0, 2, 0,        1, 1, 3, 0, 0, 0);
        vecs[7] = mk_vec(63, 255, 255, 255, 1, 0, 0, 0, 0, 243, 254, 254);

        // Reset values
        @(negedge clk);
        @(negedge clk);
        check("ready_in_reset", int'(dif.req_ready), 0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", int'(dif.req_ready), 1);
        check("busy_after_reset", int'(busy), 0);
        check("done_after_reset", int'(dif.done), 0);
        check("eject_after_reset", int'({eject_q, eject_d, eject_n}), 0);
        check("inv_after_reset", int'({inv_q, inv_d, inv_n}), 0);
        check("rem_after_reset", int'(dif.remaining), 0);

        // Zero amount: done two cycles after the handshake
        dif.req_valid  = 1'b1;
        dif.req_amount = '0;
        sb_q.push_back(mk_exp(0, 0, 0, 0, 0, 0));
        @(negedge clk);
        dif.req_valid = 1'b0;
        check("zero_busy_t1", int'(busy), 1);
        check("zero_ready_t1", int'(dif.req_ready), 0);
        check("zero_done_t1", int'(dif.done), 0);
        check("zero_eject_t1", int'({eject_q, eject_d, eject_n}), 0);
        @(negedge clk);
        check("zero_done_t2", int'(dif.done), 1);
        check("zero_busy_t2", int'(busy), 1);
        check("zero_eject_t2", int'({eject_q, eject_d, eject_n}), 0);
        @(negedge clk);
        check("zero_busy_t3", int'(busy), 0);
        check("zero_ready_t3", int'(dif.req_ready), 1);

        // Eject latency, with load and handshake in the same cycle
        inv_load       = 1'b1;
        inv_q_in       = '0;
        inv_d_in       = '0;
        inv_n_in       = 8'd1;
        dif.req_valid  = 1'b1;
        dif.req_amount = AMT_W'(1);
        sb_q.push_back(mk_exp(0, 0, 0, 0, 0, 0));
        @(negedge clk);
        inv_load      = 1'b0;
        dif.req_valid = 1'b0;
        check("lat_eject_t1", int'({eject_q, eject_d, eject_n}), 0);
        for (int i = 2; i <= 1 + PULSE; i++) begin
            @(negedge clk);
            check("lat_eject_n_high", int'({eject_q, eject_d, eject_n}), 1);
        end
        @(negedge clk);
        check("lat_eject_n_low", int'(eject_n), 0);
        coin_sensed = 1'b1;
        @(negedge clk);
        coin_sensed = 1'b0;
        check("lat_select_no_done", int'(dif.done), 0);
        @(negedge clk);
        check("lat_done", int'(dif.done), 1);
        @(negedge clk);
        check("lat_idle", int'(busy), 0);

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Reset while eject_n is high
        @(negedge clk);
        inv_load       = 1'b1;
        inv_q_in       = '0;
        inv_d_in       = '0;
        inv_n_in       = 8'd5;
        dif.req_valid  = 1'b1;
        dif.req_amount = AMT_W'(3);
        @(negedge clk);
        inv_load      = 1'b0;
        dif.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_eject_n_high", int'(eject_n), 1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_eject_n_low", int'(eject_n), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_inv", int'({inv_q, inv_d, inv_n}), 0);
        check("rst_remaining", int'(dif.remaining), 0);
        check("rst_ready_in_reset", int'(dif.req_ready), 0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready_after", int'(dif.req_ready), 1);
        check("rst_done_low", int'(dif.done), 0);

        repeat (3) @(negedge clk);
        check("sb_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
